// File: rtl/ipg_tx.sv
// Transmit-side IPG insertion: overwrites eligible idle control blocks with queued
// shim payloads (responses as type 0x1f, requests as type 0x1a); all else passes through.
module ipg_tx #(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int GUARD_IDLES    = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [63:0]                       encoded_tx_data,
  input  logic [1:0]                        encoded_tx_hdr,
  input  logic                              encoded_tx_valid,
  output logic [63:0]                       ipg_encoded_tx_data,
  output logic [1:0]                        ipg_encoded_tx_hdr,
  output logic                              ipg_encoded_tx_valid,
  input  logic [55:0]                       req_data,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [55:0]                       resp_data,
  input  logic                              resp_valid,
  output logic                              resp_ready,
  output logic [$clog2(REQ_FIFO_DEPTH):0]   req_fifo_level,
  output logic [CNT_WIDTH-1:0]              req_insert_cnt,
  output logic [CNT_WIDTH-1:0]              resp_insert_cnt
);

  localparam int AW = $clog2(REQ_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [63:0] IDLE_BLOCK = 64'h000000000000001e;

  // Handshakes: a payload transfers on a cycle where valid and ready are both high
  // at the rising edge; ready depends only on registered occupancy.

  logic [55:0]          mem_q [REQ_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 resp_full_q, resp_full_d;
  logic [55:0]          resp_data_q, resp_data_d;
  logic [3:0]           guard_q, guard_d;
  logic [CNT_WIDTH-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_WIDTH-1:0] resp_cnt_q, resp_cnt_d;
  logic [63:0]          out_data_q, out_data_d;
  logic [1:0]           out_hdr_q, out_hdr_d;
  logic                 out_valid_q, out_valid_d;

  logic is_idle, is_busy, allow, ins_resp, ins_req, push, resp_load;

  assign req_ready            = (level_q != LW'(REQ_FIFO_DEPTH));
  assign resp_ready           = !resp_full_q;
  assign req_fifo_level       = level_q;
  assign req_insert_cnt       = req_cnt_q;
  assign resp_insert_cnt      = resp_cnt_q;
  assign ipg_encoded_tx_data  = out_data_q;
  assign ipg_encoded_tx_hdr   = out_hdr_q;
  assign ipg_encoded_tx_valid = out_valid_q;

  always_comb begin
    is_idle   = encoded_tx_valid && (encoded_tx_hdr == 2'b01) && (encoded_tx_data == IDLE_BLOCK);
    is_busy   = encoded_tx_valid && !is_idle;
    allow     = is_idle && (guard_q == 4'd0);
    ins_resp  = allow && resp_full_q;
    ins_req   = allow && !resp_full_q && (level_q != '0);
    push      = req_valid && req_ready;
    resp_load = resp_valid && !resp_full_q;

    out_valid_d = encoded_tx_valid;
    out_data_d  = encoded_tx_data;
    out_hdr_d   = encoded_tx_hdr;
    if (ins_resp) begin
      out_data_d = {resp_data_q, 8'h1f};
      out_hdr_d  = 2'b01;
    end else if (ins_req) begin
      out_data_d = {mem_q[rd_ptr_q], 8'h1a};
      out_hdr_d  = 2'b01;
    end

    // Guard holds off insertion for a few idles after traffic ends.
    guard_d = guard_q;
    if (is_busy)
      guard_d = 4'(GUARD_IDLES);
    else if (is_idle && (guard_q != 4'd0))
      guard_d = guard_q - 4'd1;

    wr_ptr_d = push    ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = ins_req ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(ins_req);

    resp_full_d = resp_full_q;
    resp_data_d = resp_data_q;
    if (ins_resp) begin
      resp_full_d = 1'b0;
    end else if (resp_load) begin
      resp_full_d = 1'b1;
      resp_data_d = resp_data;
    end

    req_cnt_d  = ins_req  ? req_cnt_q + CNT_WIDTH'(1)  : req_cnt_q;
    resp_cnt_d = ins_resp ? resp_cnt_q + CNT_WIDTH'(1) : resp_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      resp_full_q <= 1'b0;
      resp_data_q <= '0;
      guard_q     <= 4'd0;
      req_cnt_q   <= '0;
      resp_cnt_q  <= '0;
      out_data_q  <= IDLE_BLOCK;
      out_hdr_q   <= 2'b01;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      resp_full_q <= resp_full_d;
      resp_data_q <= resp_data_d;
      guard_q     <= guard_d;
      req_cnt_q   <= req_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      out_data_q  <= out_data_d;
      out_hdr_q   <= out_hdr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= req_data;
  end

endmodule

// File: tb/tb_ipg_tx.sv
// Bench for ipg_tx: randomized and directed block streams against a queue-based
// reference model; a monitor pops expected output blocks one cycle after each input.
module tb_ipg_tx;

  localparam int DEPTH = 4;
  localparam int GUARD = 1;
  localparam int CW    = 4;
  localparam logic [63:0] IDLE = 64'h1e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] encoded_tx_data = IDLE;
  logic [1:0]  encoded_tx_hdr = 2'b01;
  logic        encoded_tx_valid = 1'b0;
  logic [63:0] ipg_encoded_tx_data;
  logic [1:0]  ipg_encoded_tx_hdr;
  logic        ipg_encoded_tx_valid;
  logic [55:0] req_data = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [55:0] resp_data = '0;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [2:0]  req_fifo_level;
  logic [CW-1:0] req_insert_cnt;
  logic [CW-1:0] resp_insert_cnt;

  ipg_tx #(.REQ_FIFO_DEPTH(DEPTH), .GUARD_IDLES(GUARD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .encoded_tx_data(encoded_tx_data), .encoded_tx_hdr(encoded_tx_hdr),
    .encoded_tx_valid(encoded_tx_valid),
    .ipg_encoded_tx_data(ipg_encoded_tx_data), .ipg_encoded_tx_hdr(ipg_encoded_tx_hdr),
    .ipg_encoded_tx_valid(ipg_encoded_tx_valid),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .req_fifo_level(req_fifo_level), .req_insert_cnt(req_insert_cnt),
    .resp_insert_cnt(resp_insert_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {valid, hdr, data}
  logic [66:0] exp_q[$];

  // reference model state
  logic [55:0] mdl_req_q[$];
  logic        mdl_slot_full = 1'b0;
  logic [55:0] mdl_slot = '0;
  int          mdl_guard = 0;
  int          mdl_req_cnt = 0;
  int          mdl_resp_cnt = 0;

  // payloads waiting to be offered on the req/resp ports
  logic [55:0] req_src_q[$];
  logic [55:0] resp_src_q[$];

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [55:0] rnd56();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[55:0];
  endfunction

  // One block per call: check status ports, drive inputs, advance the model.
  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d);
    logic        rq_ok, rs_ok;
    logic [63:0] od;
    logic [1:0]  oh;
    @(negedge clk);
    rq_ok = (mdl_req_q.size() < DEPTH);
    rs_ok = !mdl_slot_full;
    chk("req_ready", 67'(req_ready), 67'(rq_ok));
    chk("resp_ready", 67'(resp_ready), 67'(rs_ok));
    chk("req_fifo_level", 67'(req_fifo_level), 67'(mdl_req_q.size()));
    chk("req_insert_cnt", 67'(req_insert_cnt), 67'(mdl_req_cnt % (1 << CW)));
    chk("resp_insert_cnt", 67'(resp_insert_cnt), 67'(mdl_resp_cnt % (1 << CW)));

    encoded_tx_valid = v;
    encoded_tx_hdr   = h;
    encoded_tx_data  = d;
    req_valid  = (req_src_q.size() > 0);
    req_data   = req_valid ? req_src_q[0] : rnd56();
    resp_valid = (resp_src_q.size() > 0);
    resp_data  = resp_valid ? resp_src_q[0] : rnd56();

    od = d;
    oh = h;
    if (v && h == 2'b01 && d == IDLE) begin
      if (mdl_guard > 0) begin
        mdl_guard--;
      end else if (mdl_slot_full) begin
        od = {mdl_slot, 8'h1f};
        mdl_slot_full = 1'b0;
        mdl_resp_cnt++;
      end else if (mdl_req_q.size() > 0) begin
        od = {mdl_req_q.pop_front(), 8'h1a};
        mdl_req_cnt++;
      end
    end else if (v) begin
      mdl_guard = GUARD;
    end
    if (req_valid && rq_ok) mdl_req_q.push_back(req_src_q.pop_front());
    if (resp_valid && rs_ok) begin
      mdl_slot = resp_src_q.pop_front();
      mdl_slot_full = 1'b1;
    end
    exp_q.push_back({v, oh, od});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    encoded_tx_valid = 1'b0;
    req_valid = 1'b0;
    resp_valid = 1'b0;
    #1;
    chk("reset_out", {ipg_encoded_tx_valid, ipg_encoded_tx_hdr, ipg_encoded_tx_data},
        {1'b0, 2'b01, IDLE});
    chk("reset_level", 67'(req_fifo_level), 67'd0);
    chk("reset_cnts", 67'({req_insert_cnt, resp_insert_cnt}), 67'd0);
    mdl_req_q.delete();
    req_src_q.delete();
    resp_src_q.delete();
    exp_q.delete();
    mdl_slot_full = 1'b0;
    mdl_guard = 0;
    mdl_req_cnt = 0;
    mdl_resp_cnt = 0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_blk();
    step(1'b1, 2'b01, IDLE);
  endtask

  task automatic data_blk();
    step(1'b1, 2'b10, {$urandom, $urandom});
  endtask

  task automatic rand_blk();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3, 4: idle_blk();
      5:       step(1'b0, 2'b01, IDLE);
      6:       step(1'b1, 2'b01, {rnd56(), 8'h2d});
      7:       step(1'b1, 2'b01, {24'h0, 8'h01, 24'h0, 8'h1e});
      8:       step(1'b1, 2'b10, IDLE);
      default: data_blk();
    endcase
  endtask

  // monitor
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [66:0] e;
      e = exp_q.pop_front();
      chk("out_block", {ipg_encoded_tx_valid, ipg_encoded_tx_hdr, ipg_encoded_tx_data}, e);
    end
  end

  initial begin
    do_reset(3);

    // single request behind a data block
    req_src_q.push_back(56'h11223344556677);
    step(1'b0, 2'b10, 64'h0);
    data_blk();
    repeat (3) idle_blk();

    // response priority over request
    req_src_q.push_back(56'hAAAAAAAAAAAAAA);
    resp_src_q.push_back(56'hBBBBBBBBBBBBBB);
    data_blk();
    repeat (4) idle_blk();

    // queue full, fifth held off
    for (int i = 1; i <= 5; i++) req_src_q.push_back(56'(i));
    repeat (6) data_blk();
    repeat (8) idle_blk();

    // pause and non-idle control with a request pending
    req_src_q.push_back(56'h77);
    data_blk();
    idle_blk();
    step(1'b0, 2'b01, IDLE);
    step(1'b1, 2'b01, {56'h0, 8'h2d});
    repeat (3) idle_blk();

    // reset mid-stream
    for (int i = 0; i < 3; i++) req_src_q.push_back(rnd56());
    resp_src_q.push_back(rnd56());
    repeat (4) data_blk();
    do_reset(1);
    repeat (4) idle_blk();

    // randomized traffic; CW=4 makes the insert counters wrap
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0 && req_src_q.size() < 3) req_src_q.push_back(rnd56());
      if ($urandom_range(0, 7) == 0 && resp_src_q.size() < 2) resp_src_q.push_back(rnd56());
      rand_blk();
      if (i == 1000) do_reset($urandom_range(1, 3));
    end

    repeat (20) idle_blk();
    repeat (2) @(negedge clk);
    chk("drain", 67'(exp_q.size()), 67'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
